// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the CAN-to-UART bridge transmit path.
package uart_bridge_pkg;

   localparam int BYTE_W            = 8;
   localparam int DEF_CLKS_PER_TICK = 16;
   localparam int DEF_FRAME_CYCLES  = 12;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_TICK,
      SEND,
      COOLDOWN
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus transmitter strobes for the shared UART transmitter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
   import uart_bridge_pkg::*;

   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [BYTE_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      Byte_ready;
   logic                      Load_XMT_datareg;
   logic                      T_byte;
   logic [BYTE_W-1:0]         Data_Bus;
   logic [IW-1:0]             grant_id;
   logic                      busy;

   modport slave (
      input  req_valid, req_data,
      output req_ready, Byte_ready, Load_XMT_datareg, T_byte, Data_Bus, grant_id, busy
   );

   modport master (
      output req_valid, req_data,
      input  req_ready, Byte_ready, Load_XMT_datareg, T_byte, Data_Bus, grant_id, busy
   );

endinterface

// File: rtl/uart_tick_gen.sv
// Free-running divider: tick is high for the single cycle where the count is CLKS_PER_TICK-1.
module uart_tick_gen #(
   parameter int CLKS_PER_TICK = 16
) (
   input  logic clock,
   input  logic reset_n,
   output logic tick
);

   localparam int TW = $clog2(CLKS_PER_TICK);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_TICK - 1);

   logic [TW-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Optional: define UART_ARB_PRIORITY_EN to give requester 0 absolute precedence.
module uart_tx_arbiter
   import uart_bridge_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
   parameter int FRAME_CYCLES  = DEF_FRAME_CYCLES
) (
   input  logic               clock,
   input  logic               reset_n,
   uart_tx_arbiter_if.slave   bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(FRAME_CYCLES);

   arb_state_t    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] win;
   logic          found;
   logic [CW-1:0] cooldown;
   logic          tick;
   int            cand;

   uart_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // Search starts one past the last winner so every requester gets its turn.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
`ifdef UART_ARB_PRIORITY_EN
         if (!found && cand != 0 && bus.req_valid[cand]) begin
`else
         if (!found && bus.req_valid[cand]) begin
`endif
            found = 1'b1;
            win   = IW'(cand);
         end
      end
`ifdef UART_ARB_PRIORITY_EN
      if (bus.req_valid[0]) begin
         found = 1'b1;
         win   = '0;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                <= IDLE;
         ptr                  <= '0;
         cooldown             <= '0;
         bus.req_ready        <= '0;
         bus.Byte_ready       <= 1'b0;
         bus.Load_XMT_datareg <= 1'b0;
         bus.T_byte           <= 1'b0;
         bus.Data_Bus         <= '0;
         bus.grant_id         <= '0;
         bus.busy             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  bus.req_ready <= NUM_REQ'(1) << win;
                  bus.Data_Bus  <= bus.req_data[int'(win)*BYTE_W +: BYTE_W];
                  bus.grant_id  <= win;
                  bus.busy      <= 1'b1;
`ifdef UART_ARB_PRIORITY_EN
                  if (win != '0) ptr <= win;
`else
                  ptr <= win;
`endif
                  state <= LOAD;
               end
            end
            LOAD: begin
               bus.req_ready        <= '0;
               bus.Byte_ready       <= 1'b1;
               bus.Load_XMT_datareg <= 1'b1;
               state                <= WAIT_TICK;
            end
            WAIT_TICK: begin
               bus.Byte_ready       <= 1'b0;
               bus.Load_XMT_datareg <= 1'b0;
               if (tick) begin
                  bus.T_byte <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               bus.T_byte <= 1'b0;
               cooldown   <= CW'(FRAME_CYCLES - 1);
               state      <= COOLDOWN;
            end
            COOLDOWN: begin
               // Leaving as the count reaches zero puts IDLE exactly FRAME_CYCLES after T_byte.
               cooldown <= cooldown - 1'b1;
               if (cooldown == CW'(1)) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
